// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/bubble steering, halt sequencing on
// memory/writeback exceptions, and saturating performance counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic [1:0]  m_stat,
    input  logic [1:0]  W_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        set_cc,
    output logic        halted,
    output logic [1:0]  exc_code,
    output logic [31:0] cyc_cnt,
    output logic [31:0] lu_cnt,
    output logic [31:0] mp_cnt,
    output logic [31:0] ret_cnt
);

    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hb;
    localparam logic [3:0] R_NONE   = 4'hf;
    localparam logic [1:0] S_AOK    = 2'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_nx;

    logic loaduse, mispred, retpend, mexc, wexc, active;

    assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                     (E_dstM != R_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mispred = (E_icode == I_JXX) && !e_Cnd;
    assign retpend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mexc    = (m_stat != S_AOK);
    assign wexc    = (W_stat != S_AOK);
    assign active  = (state != HALTED);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // Next-state and pipeline control outputs; reset forces a flush
    always_comb begin
        state_nx = state;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        if (rst) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state)
                RUN, DRAIN: begin
                    F_stall  = loaduse || retpend;
                    D_stall  = loaduse;
                    D_bubble = mispred || (retpend && !loaduse);
                    E_bubble = mispred || loaduse;
                    M_bubble = mexc || wexc;
                    W_stall  = wexc;
                    set_cc   = (E_icode == I_OPQ) && !mexc && !wexc;
                    if (wexc)                       state_nx = HALTED;
                    else if (mexc && state == RUN)  state_nx = DRAIN;
                end
                HALTED: begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // Halt flag and terminating status, captured on entry to HALTED
    always_ff @(posedge clk) begin
        if (rst) begin
            halted   <= 1'b0;
            exc_code <= S_AOK;
        end else if (active && wexc) begin
            halted   <= 1'b1;
            exc_code <= W_stat;
        end
    end

    // Saturating performance counters, frozen once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
            lu_cnt  <= '0;
            mp_cnt  <= '0;
            ret_cnt <= '0;
        end else if (active) begin
            if (cyc_cnt != '1)                       cyc_cnt <= cyc_cnt + 32'd1;
            if (loaduse && lu_cnt != '1)             lu_cnt  <= lu_cnt + 32'd1;
            if (mispred && mp_cnt != '1)             mp_cnt  <= mp_cnt + 32'd1;
            if (retpend && !loaduse && ret_cnt != '1) ret_cnt <= ret_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios followed by randomized
// traffic, all checked against a behavioural model of the control rules.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
    logic        e_Cnd;
    logic [1:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic        halted;
    logic [1:0]  exc_code;
    logic [31:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Model: mode 0 = running, 1 = draining, 2 = halted
    int          m_mode   = 0;
    bit          m_halted = 0;
    bit [1:0]    m_exc    = 0;
    longint      m_cyc = 0, m_lu = 0, m_mp = 0, m_ret = 0;
    int unsigned halt_age = 0;

    localparam longint SAT = 64'h0000_0000_FFFF_FFFF;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .set_cc(set_cc), .halted(halted), .exc_code(exc_code),
        .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_loaduse();
        return ((E_icode == 4'h5) || (E_icode == 4'hb)) && (E_dstM != 4'hf) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic bit is_mispred();
        return (E_icode == 4'h7) && !e_Cnd;
    endfunction

    function automatic bit is_retpend();
        return (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    function automatic logic [6:0] expect_ctrl();
        bit lu, mp, rp, me, we;
        lu = is_loaduse(); mp = is_mispred(); rp = is_retpend();
        me = (m_stat != 0); we = (W_stat != 0);
        if (rst)          return 7'b0011100;
        if (m_mode == 2)  return 7'b1100010;
        return {lu || rp, lu, mp || (rp && !lu), mp || lu, me || we, we,
                (E_icode == 4'h6) && !me && !we};
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    // Apply the model's response to one clock edge using the current inputs
    task automatic model_edge();
        bit lu, mp, rp;
        lu = is_loaduse(); mp = is_mispred(); rp = is_retpend();
        if (rst) begin
            m_mode = 0; m_halted = 0; m_exc = 0;
            m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
        end else if (m_mode != 2) begin
            m_cyc = sat_inc(m_cyc);
            if (lu)        m_lu  = sat_inc(m_lu);
            if (mp)        m_mp  = sat_inc(m_mp);
            if (rp && !lu) m_ret = sat_inc(m_ret);
            if (W_stat != 0) begin
                m_mode = 2; m_halted = 1; m_exc = W_stat;
            end else if (m_stat != 0 && m_mode == 0) begin
                m_mode = 1;
            end
        end
    endtask

    // One cycle: inputs already driven just after an edge
    task automatic step();
        #2;
        check("ctrl", {25'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc},
              {25'd0, expect_ctrl()});
        check("d_stall_bubble_excl", {31'd0, D_stall & D_bubble}, 32'd0);
        @(posedge clk);
        model_edge();
        #1;
        check("halted",   {31'd0, halted},   {31'd0, m_halted});
        check("exc_code", {30'd0, exc_code}, {30'd0, m_exc});
        check("cyc_cnt",  cyc_cnt, m_cyc[31:0]);
        check("lu_cnt",   lu_cnt,  m_lu[31:0]);
        check("mp_cnt",   mp_cnt,  m_mp[31:0]);
        check("ret_cnt",  ret_cnt, m_ret[31:0]);
    endtask

    task automatic idle();
        rst = 1'b0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
        d_srcA = 4'hf; d_srcB = 4'hf; E_dstM = 4'hf;
        e_Cnd = 1'b1; m_stat = 2'd0; W_stat = 2'd0;
    endtask

    function automatic logic [3:0] pick_icode();
        logic [3:0] tbl [8];
        tbl = '{4'h0, 4'h1, 4'h6, 4'h7, 4'h8, 4'h9, 4'h5, 4'hb};
        return tbl[$urandom_range(7)];
    endfunction

    function automatic logic [3:0] pick_reg();
        return ($urandom_range(4) == 0) ? 4'hf : 4'($urandom_range(3));
    endfunction

    task automatic drive_random();
        D_icode = pick_icode(); E_icode = pick_icode(); M_icode = pick_icode();
        d_srcA  = pick_reg();   d_srcB  = pick_reg();   E_dstM  = pick_reg();
        e_Cnd   = 1'($urandom_range(1));
        m_stat  = ($urandom_range(15) == 0) ? 2'($urandom_range(3)) : 2'd0;
        W_stat  = ($urandom_range(39) == 0) ? 2'($urandom_range(3)) : 2'd0;
        rst     = ($urandom_range(79) == 0) || (halt_age > 6);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        step(); step();

        // Load-use on srcA
        idle(); E_icode = 4'h5; E_dstM = 4'd3; d_srcA = 4'd3;
        step(); step();
        // Mispredicted and correctly-taken jump
        idle(); E_icode = 4'h7; e_Cnd = 1'b0; step();
        e_Cnd = 1'b1; step();
        // Three cycles of RET in decode
        idle(); D_icode = 4'h9;
        step(); step(); step();
        // Load-use overrides ret bubble
        idle(); D_icode = 4'h9; E_icode = 4'hb; E_dstM = 4'd2; d_srcB = 4'd2;
        step();
        // Memory exception drains, writeback exception halts
        idle(); E_icode = 4'h6; m_stat = 2'd2; step();
        m_stat = 2'd0; W_stat = 2'd2; step();
        W_stat = 2'd0; step(); step();
        // Reset out of HALTED
        rst = 1'b1; step();
        idle(); step();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
            halt_age = (m_mode == 2) ? halt_age + 1 : 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
